// File: rtl/sram_wait_model.sv
// sram_wait_model: clocked SRAM stand-in with req/ready handshake,
// programmable read/write wait states, byte-lane write strobes and
// out-of-range error reporting. One access in flight at a time.
module sram_wait_model #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 20,
  parameter int DEPTH     = 2**ADDR_W,
  parameter int RD_WAIT   = 2,
  parameter int WR_WAIT   = 1,
  parameter     INIT_FILE = ""
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic                  ready,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [DATA_W-1:0]     rdata
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Out-of-range test is done one bit wider than the address so that
  // DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  localparam logic [7:0] RD_N = 8'(RD_WAIT);
  localparam logic [7:0] WR_N = 8'(WR_WAIT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Illegal parameterisations stop elaboration.
  if (DATA_W <= 0 || (DATA_W % 8) != 0) begin : g_bad_data_w
    $fatal(1, "sram_wait_model: DATA_W must be a positive multiple of 8");
  end
  if (RD_WAIT < 0 || RD_WAIT > 255) begin : g_bad_rd_wait
    $fatal(1, "sram_wait_model: RD_WAIT must be in 0..255");
  end
  if (WR_WAIT < 0 || WR_WAIT > 255) begin : g_bad_wr_wait
    $fatal(1, "sram_wait_model: WR_WAIT must be in 0..255");
  end
  if (DEPTH < 1 || longint'(DEPTH) > (longint'(1) << ADDR_W)) begin : g_bad_depth
    $fatal(1, "sram_wait_model: DEPTH must be in 1..2**ADDR_W");
  end

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [1:0]        r_state;
  logic [7:0]        r_cnt;
  logic              r_err;
  logic [DATA_W-1:0] r_rdata;

  logic              r_we;
  logic [BYTES-1:0]  r_be;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic [1:0]        w_state_nxt;
  logic [7:0]        w_cnt_nxt;
  logic [7:0]        w_n;
  logic              w_accept;
  logic              w_commit;
  logic              w_acc_we;
  logic [BYTES-1:0]  w_acc_be;
  logic [ADDR_W-1:0] w_acc_addr;
  logic [DATA_W-1:0] w_acc_wdata;
  logic              w_in_range;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_rd_word;

  assign ready      = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_err   = resp_valid & r_err;
  assign rdata      = r_rdata;

  assign w_n = we ? WR_N : RD_N;

  // With zero wait states the access commits on the accept edge itself,
  // before the request fields are latched, so the commit path takes the
  // live inputs while idle and the latched copy otherwise.
  assign w_acc_we    = (r_state == S_IDLE) ? we    : r_we;
  assign w_acc_be    = (r_state == S_IDLE) ? be    : r_be;
  assign w_acc_addr  = (r_state == S_IDLE) ? addr  : r_addr;
  assign w_acc_wdata = (r_state == S_IDLE) ? wdata : r_wdata;

  assign w_in_range = ({1'b0, w_acc_addr} < DEPTH_L);
  assign w_idx      = w_acc_addr[IDX_W-1:0];
  assign w_rd_word  = r_mem[w_idx];

  // The access is performed on the edge that moves the FSM into RESP.
  assign w_commit = (w_state_nxt == S_RESP) && (r_state != S_RESP);

  // Next-state and wait-counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_accept = 1'b1;
          if (w_n == 8'd0) begin
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = w_n;
          end
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 8'd1;
        if (r_cnt == 8'd1) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Control state, error flag and read-data register; reset aborts any
  // access in flight because the FSM is forced back to IDLE before the
  // committing edge can occur.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_commit) begin
        r_err <= ~w_in_range;
        if (!w_acc_we) begin
          r_rdata <= w_in_range ? w_rd_word : '0;
        end
      end
    end
  end

  // Request fields are captured at accept and held until the response.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= we;
      r_be    <= be;
      r_addr  <= addr;
      r_wdata <= wdata;
    end
  end

  // Byte-lane write into the array; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_commit && w_acc_we && w_in_range) begin
      for (int i = 0; i < BYTES; i++) begin
        if (w_acc_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_wait_model.sv
// Self-checking bench for sram_wait_model: three instances with different
// wait-state / depth settings share data inputs but have private req lines.
module tb_sram_wait_model;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  req_v;
  logic        we_s;
  logic [1:0]  be_s;
  logic [19:0] addr_s;
  logic [15:0] wdata_s;
  logic [2:0]  ready_v;
  logic [2:0]  rv_v;
  logic [2:0]  err_v;
  logic [15:0] rdata_v [3];

  int checks = 0;
  int errors = 0;

  logic [15:0] mdl [int];
  logic [15:0] last_rd [3];

  always #5 clk = ~clk;

  sram_wait_model #(.DATA_W(16), .ADDR_W(20), .DEPTH(1 << 20), .RD_WAIT(2), .WR_WAIT(1)) u0 (
    .clk(clk), .rst_n(rst_n), .req(req_v[0]), .we(we_s), .be(be_s), .addr(addr_s),
    .wdata(wdata_s), .ready(ready_v[0]), .resp_valid(rv_v[0]), .resp_err(err_v[0]),
    .rdata(rdata_v[0]));

  sram_wait_model #(.DATA_W(16), .ADDR_W(20), .DEPTH(4096), .RD_WAIT(0), .WR_WAIT(0)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req_v[1]), .we(we_s), .be(be_s), .addr(addr_s),
    .wdata(wdata_s), .ready(ready_v[1]), .resp_valid(rv_v[1]), .resp_err(err_v[1]),
    .rdata(rdata_v[1]));

  sram_wait_model #(.DATA_W(16), .ADDR_W(20), .DEPTH(1024), .RD_WAIT(3), .WR_WAIT(4)) u2 (
    .clk(clk), .rst_n(rst_n), .req(req_v[2]), .we(we_s), .be(be_s), .addr(addr_s),
    .wdata(wdata_s), .ready(ready_v[2]), .resp_valid(rv_v[2]), .resp_err(err_v[2]),
    .rdata(rdata_v[2]));

  function automatic int depth_of(input int sel);
    case (sel)
      0: return 1 << 20;
      1: return 4096;
      default: return 1024;
    endcase
  endfunction

  function automatic int wr_wait_of(input int sel);
    case (sel)
      0: return 1;
      1: return 0;
      default: return 4;
    endcase
  endfunction

  function automatic int rd_wait_of(input int sel);
    case (sel)
      0: return 2;
      1: return 0;
      default: return 3;
    endcase
  endfunction

  function automatic logic [19:0] win_addr(input int sel, input int i);
    if (i < 6) return 20'(i);
    case (sel)
      0: return (i == 6) ? 20'hFFFFE : 20'hFFFFF;
      1: return (i == 6) ? 20'd4095 : 20'd4096;
      default: return (i == 6) ? 20'd1023 : 20'd1024;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on instance sel, checked against the model:
  // handshake, latency in edges after accept, busy ready, error flag,
  // read data / rdata hold, and return to idle.
  task automatic txn(input int sel, input bit w, input logic [1:0] b,
                     input logic [19:0] a, input logic [15:0] d,
                     input bit wiggle, output logic [15:0] rd_o);
    int n;
    int c;
    int key;
    bit seen;
    bit exp_err;
    logic [15:0] exp_rd;
    logic [15:0] cur;
    n       = w ? wr_wait_of(sel) : rd_wait_of(sel);
    exp_err = (int'(a) >= depth_of(sel));
    key     = sel * (1 << 21) + int'(a);
    we_s = w; be_s = b; addr_s = a; wdata_s = d;
    req_v[sel] = 1'b1;
    chk("ready_idle", 32'(ready_v[sel]), 32'd1);
    tick();
    if (!wiggle) req_v[sel] = 1'b0;
    c = 0;
    seen = 1'b0;
    while (!seen && c <= 300) begin
      chk("ready_busy", 32'(ready_v[sel]), 32'd0);
      if (rv_v[sel]) begin
        seen = 1'b1;
      end else begin
        chk("err_without_valid", 32'(err_v[sel]), 32'd0);
        if (wiggle) begin
          addr_s  = 20'h200;
          wdata_s = 16'($urandom);
          we_s    = 1'($urandom);
          be_s    = 2'($urandom);
        end
        tick();
        c++;
      end
    end
    req_v[sel] = 1'b0;
    chk("latency", seen ? 32'(c) : 32'hFFFF_FFFF, 32'(n));
    chk("resp_err", 32'(err_v[sel]), 32'(exp_err));
    rd_o = rdata_v[sel];
    if (!w) begin
      if (exp_err) exp_rd = 16'h0000;
      else if (mdl.exists(key)) exp_rd = mdl[key];
      else exp_rd = rdata_v[sel];
      if (exp_err || mdl.exists(key)) chk("rdata", 32'(rdata_v[sel]), 32'(exp_rd));
      last_rd[sel] = exp_rd;
    end else begin
      chk("rdata_hold", 32'(rdata_v[sel]), 32'(last_rd[sel]));
      if (!exp_err) begin
        cur = mdl.exists(key) ? mdl[key] : 16'h0000;
        for (int i = 0; i < 2; i++) begin
          if (b[i]) cur[8*i +: 8] = d[8*i +: 8];
        end
        mdl[key] = cur;
      end
    end
    tick();
    chk("resp_one_cycle", 32'(rv_v[sel]), 32'd0);
    chk("ready_after", 32'(ready_v[sel]), 32'd1);
  endtask

  // Hard stop if the stimulus ever stalls.
  initial begin
    #5_000_000;
    $display("FAIL global_timeout observed=stall expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] rd;
    logic [15:0] dj;
    logic [19:0] a;
    int sel;
    req_v = 3'b000; we_s = 1'b0; be_s = 2'b00; addr_s = '0; wdata_s = '0;
    for (int s = 0; s < 3; s++) last_rd[s] = 16'h0000;

    // Reset state.
    #2 rst_n = 1'b0;
    repeat (3) tick();
    for (int s = 0; s < 3; s++) begin
      chk("rst_ready", 32'(ready_v[s]), 32'd1);
      chk("rst_resp_valid", 32'(rv_v[s]), 32'd0);
      chk("rst_resp_err", 32'(err_v[s]), 32'd0);
      chk("rst_rdata", 32'(rdata_v[s]), 32'd0);
    end
    rst_n = 1'b1;
    tick();

    // Write then read back with default wait states.
    txn(0, 1'b1, 2'b11, 20'h00010, 16'hA5A5, 1'b0, rd);
    txn(0, 1'b1, 2'b11, 20'h00123, 16'hBEEF, 1'b0, rd);
    txn(0, 1'b0, 2'b00, 20'h00123, 16'h0000, 1'b0, rd);
    chk("t2_read", 32'(rd), 32'hBEEF);

    // Byte strobes.
    txn(0, 1'b1, 2'b01, 20'h00123, 16'h1234, 1'b0, rd);
    txn(0, 1'b0, 2'b11, 20'h00123, 16'h0000, 1'b0, rd);
    chk("t3_be01", 32'(rd), 32'hBE34);
    txn(0, 1'b1, 2'b10, 20'h00123, 16'h5600, 1'b0, rd);
    txn(0, 1'b0, 2'b01, 20'h00123, 16'h0000, 1'b0, rd);
    chk("t3_be10", 32'(rd), 32'h5634);
    txn(0, 1'b1, 2'b00, 20'h00123, 16'hFFFF, 1'b0, rd);
    txn(0, 1'b0, 2'b00, 20'h00123, 16'h0000, 1'b0, rd);
    chk("t3_be00", 32'(rd), 32'h5634);

    // Reset in the middle of a write wait.
    we_s = 1'b1; be_s = 2'b11; addr_s = 20'h00010; wdata_s = 16'h1111;
    req_v[0] = 1'b1;
    tick();
    req_v[0] = 1'b0;
    chk("t1_in_wait", 32'(ready_v[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("t1_ready", 32'(ready_v[0]), 32'd1);
    chk("t1_resp_valid", 32'(rv_v[0]), 32'd0);
    chk("t1_rdata", 32'(rdata_v[0]), 32'd0);
    tick();
    chk("t1_no_resp", 32'(rv_v[0]), 32'd0);
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) last_rd[s] = 16'h0000;
    tick();
    chk("t1_no_late_resp", 32'(rv_v[0]), 32'd0);
    txn(0, 1'b0, 2'b11, 20'h00010, 16'h0000, 1'b0, rd);
    chk("t1_contents", 32'(rd), 32'hA5A5);

    // Zero wait states, req held high back to back.
    req_v[1] = 1'b1;
    we_s = 1'b1; be_s = 2'b11; addr_s = 20'd0; wdata_s = 16'hC000;
    for (int j = 0; j < 8; j++) begin
      chk("b2b_ready", 32'(ready_v[1]), 32'd1);
      chk("b2b_idle_valid", 32'(rv_v[1]), 32'd0);
      tick();
      chk("b2b_resp", 32'(rv_v[1]), 32'd1);
      chk("b2b_busy", 32'(ready_v[1]), 32'd0);
      if (j >= 4) begin
        dj = 16'hC000 + 16'(j - 4) * 16'h0111;
        chk("b2b_rdata", 32'(rdata_v[1]), 32'(dj));
        last_rd[1] = dj;
      end else begin
        mdl[1 * (1 << 21) + j] = 16'hC000 + 16'(j) * 16'h0111;
      end
      if (j < 7) begin
        we_s    = (j + 1) < 4;
        addr_s  = 20'((j + 1) % 4);
        wdata_s = 16'hC000 + 16'(j + 1) * 16'h0111;
      end else begin
        req_v[1] = 1'b0;
      end
      tick();
    end
    chk("b2b_done", 32'(ready_v[1]), 32'd1);

    // Out-of-range accesses.
    txn(2, 1'b1, 2'b11, 20'd0, 16'h0F0F, 1'b0, rd);
    txn(2, 1'b0, 2'b11, 20'd1024, 16'h0000, 1'b0, rd);
    chk("t5_err_rdata", 32'(rd), 32'd0);
    txn(2, 1'b1, 2'b11, 20'd1024, 16'hDEAD, 1'b0, rd);
    txn(2, 1'b0, 2'b11, 20'd0, 16'h0000, 1'b0, rd);
    chk("t5_addr0", 32'(rd), 32'h0F0F);

    // Inputs change while busy; only the accepted request counts.
    txn(0, 1'b1, 2'b11, 20'h00200, 16'h7777, 1'b0, rd);
    txn(0, 1'b1, 2'b11, 20'h00300, 16'h4242, 1'b1, rd);
    txn(0, 1'b0, 2'b11, 20'h00300, 16'h0000, 1'b1, rd);
    chk("t6_target", 32'(rd), 32'h4242);
    txn(0, 1'b0, 2'b11, 20'h00200, 16'h0000, 1'b0, rd);
    chk("t6_untouched", 32'(rd), 32'h7777);

    // Randomised traffic against the model on every instance.
    for (sel = 0; sel < 3; sel++) begin
      for (int i = 0; i < 8; i++) begin
        a = win_addr(sel, i);
        if (int'(a) < depth_of(sel))
          txn(sel, 1'b1, 2'b11, a, 16'($urandom), 1'b0, rd);
      end
      for (int k = 0; k < 30; k++) begin
        a = win_addr(sel, int'($urandom_range(0, 7)));
        txn(sel, 1'($urandom), 2'($urandom), a, 16'($urandom), 1'b0, rd);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
